// File: rtl/pipeline_control.sv
// pipeline_control: hazard, forwarding and write-enable controller for a
// 5-stage RV32I pipeline. Decodes IR2..IR5 plus the registered branch-taken
// flag and drives every datapath mux select and both write enables.
// All outputs are combinational. A single registered "armed" bit holds the
// pipeline in a safe, flushing state until the first clock edge after reset
// is released.
module pipeline_control (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] ir2_output,
  input  logic [31:0] ir3_output,
  input  logic [31:0] ir4_output,
  input  logic [31:0] ir5_output,
  input  logic        branch_control_output,
  output logic [1:0]  select_pc,
  output logic [1:0]  select_ir2,
  output logic        select_pc2,
  output logic        select_pc3,
  output logic [1:0]  select_ir3,
  output logic        select_ir4,
  output logic [1:0]  select_x3,
  output logic [1:0]  select_y3,
  output logic [1:0]  select_md3,
  output logic [1:0]  select_operand1,
  output logic [1:0]  select_operand2,
  output logic [1:0]  select_md4,
  output logic        select_datawrite,
  output logic [1:0]  select_z5,
  output logic        reg_write_enable,
  output logic        data_write_signal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Opcode classes. rd != 0 is checked separately for writers.
  function automatic logic f_writes(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LOAD) || (op == OP_OPIMM) ||
           (op == OP_OP);
  endfunction

  function automatic logic f_uses_rs1(input logic [6:0] op);
    return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_OPIMM) || (op == OP_OP);
  endfunction

  function automatic logic f_uses_rs2(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
  endfunction

  // Instructions whose Y operand comes from the immediate generator.
  function automatic logic f_imm_y(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_OPIMM);
  endfunction

  // Field extraction per stage.
  logic [6:0] op2, op3, op4, op5;
  logic [4:0] rs1_2, rs2_2;
  logic [4:0] rd3, rs1_3, rs2_3;
  logic [4:0] rd4, rs2_4;
  logic [4:0] rd5;
  logic       wr4, wr5;
  logic       redirect, load_use;
  logic       armed_d, armed_q;
  logic       unused_bits;

  assign op2   = ir2_output[6:0];
  assign rs1_2 = ir2_output[19:15];
  assign rs2_2 = ir2_output[24:20];

  assign op3   = ir3_output[6:0];
  assign rd3   = ir3_output[11:7];
  assign rs1_3 = ir3_output[19:15];
  assign rs2_3 = ir3_output[24:20];

  assign op4   = ir4_output[6:0];
  assign rd4   = ir4_output[11:7];
  assign rs2_4 = ir4_output[24:20];

  assign op5   = ir5_output[6:0];
  assign rd5   = ir5_output[11:7];

  // Immediate / funct bits are the datapath's concern, not the controller's.
  assign unused_bits = ^{ir2_output[31:25], ir2_output[14:7],
                         ir3_output[31:25], ir3_output[14:12],
                         ir4_output[31:25], ir4_output[19:12],
                         ir5_output[31:12]};

  // Writers into the register file; x0 never counts as a producer.
  assign wr4 = f_writes(op4) && (rd4 != 5'd0);
  assign wr5 = f_writes(op5) && (rd5 != 5'd0);

  // Control transfer resolved in the memory stage.
  assign redirect = (op4 == OP_JAL) || (op4 == OP_JALR) ||
                    ((op4 == OP_BRANCH) && branch_control_output);

  // A load in execute feeding the instruction in decode. A store's data
  // register (rs2) is excluded: that value is forwarded late via
  // select_datawrite, so no bubble is needed for it.
  assign load_use = (op3 == OP_LOAD) && (rd3 != 5'd0) &&
                    ((f_uses_rs1(op2) && (rd3 == rs1_2)) ||
                     (f_uses_rs2(op2) && (op2 != OP_STORE) && (rd3 == rs2_2)));

  assign armed_d = 1'b1;

  // Arm the controller on the first edge that samples reset released.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  // Select and enable decode, gated to safe values while disarmed.
  always_comb begin
    select_pc         = 2'd0;
    select_ir2        = 2'd0;
    select_pc2        = 1'b0;
    select_pc3        = 1'b0;
    select_ir3        = 2'd0;
    select_ir4        = 1'b0;
    select_x3         = 2'd0;
    select_y3         = 2'd0;
    select_md3        = 2'd0;
    select_operand1   = 2'd0;
    select_operand2   = 2'd0;
    select_md4        = 2'd0;
    select_datawrite  = 1'b0;
    select_z5         = 2'd0;
    reg_write_enable  = 1'b0;
    data_write_signal = 1'b0;

    if (!armed_q) begin
      // Flush every stage and write nothing until armed.
      select_ir2 = 2'd1;
      select_ir3 = 2'd1;
      select_ir4 = 1'b1;
    end else begin
      // Decode stage: X/Y/MD operand sources, with writeback bypass.
      if ((op2 == OP_AUIPC) || (op2 == OP_JAL)) begin
        select_x3 = 2'd2;
      end else if (op2 == OP_LUI) begin
        select_x3 = 2'd3;
      end else if (wr5 && (rd5 == rs1_2)) begin
        select_x3 = 2'd1;
      end

      if (f_imm_y(op2)) begin
        select_y3 = 2'd2;
      end else if (wr5 && (rd5 == rs2_2)) begin
        select_y3 = 2'd1;
      end

      if (wr5 && (rd5 == rs2_2)) begin
        select_md3 = 2'd1;
      end

      // Execute stage: forward from memory (non-load) first, then writeback.
      if (f_uses_rs1(op3)) begin
        if (wr4 && (op4 != OP_LOAD) && (rd4 == rs1_3)) begin
          select_operand1 = 2'd1;
        end else if (wr5 && (rd5 == rs1_3)) begin
          select_operand1 = 2'd2;
        end
      end

      if ((op3 == OP_OP) || (op3 == OP_BRANCH)) begin
        if (wr4 && (op4 != OP_LOAD) && (rd4 == rs2_3)) begin
          select_operand2 = 2'd1;
        end else if (wr5 && (rd5 == rs2_3)) begin
          select_operand2 = 2'd2;
        end
      end

      if (op3 == OP_STORE) begin
        if (wr4 && (op4 != OP_LOAD) && (rd4 == rs2_3)) begin
          select_md4 = 2'd1;
        end else if (wr5 && (rd5 == rs2_3)) begin
          select_md4 = 2'd2;
        end
      end

      // Memory stage: store enable and load-to-store data bypass.
      data_write_signal = (op4 == OP_STORE);
      select_datawrite  = (op4 == OP_STORE) && (op5 == OP_LOAD) &&
                          (rd5 == rs2_4) && (rs2_4 != 5'd0);

      // Writeback stage: result source and register-file enable.
      if (op5 == OP_LOAD) begin
        select_z5 = 2'd1;
      end else if ((op5 == OP_JAL) || (op5 == OP_JALR)) begin
        select_z5 = 2'd2;
      end
      reg_write_enable = wr5;

      // Hazard handling: a redirect flushes and takes priority over a stall.
      if (redirect) begin
        select_pc  = (op4 == OP_JALR) ? 2'd2 : 2'd1;
        select_ir2 = 2'd1;
        select_ir3 = 2'd1;
        select_ir4 = 1'b1;
      end else if (load_use) begin
        select_pc  = 2'd3;
        select_ir2 = 2'd2;
        select_pc2 = 1'b1;
        select_ir3 = 2'd1;
        select_pc3 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed scoreboard bench for pipeline_control.
// Each driven vector pushes its hand-derived expected output word onto
// exp_q; the monitor pops and compares on the falling edge.
module tb_pipeline_control;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] ir2;
    logic       pc2;
    logic       pc3;
    logic [1:0] ir3;
    logic       ir4;
    logic [1:0] x3;
    logic [1:0] y3;
    logic [1:0] md3;
    logic [1:0] op1;
    logic [1:0] op2;
    logic [1:0] md4;
    logic       dwsel;
    logic [1:0] z5;
    logic       rwe;
    logic       dws;
  } out_t;

  localparam int W = 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ir2_output = '0;
  logic [31:0] ir3_output = '0;
  logic [31:0] ir4_output = '0;
  logic [31:0] ir5_output = '0;
  logic        branch_control_output = 1'b0;

  logic [1:0] select_pc, select_ir2, select_ir3, select_x3, select_y3, select_md3;
  logic [1:0] select_operand1, select_operand2, select_md4, select_z5;
  logic       select_pc2, select_pc3, select_ir4, select_datawrite;
  logic       reg_write_enable, data_write_signal;

  pipeline_control dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .ir2_output            (ir2_output),
    .ir3_output            (ir3_output),
    .ir4_output            (ir4_output),
    .ir5_output            (ir5_output),
    .branch_control_output (branch_control_output),
    .select_pc             (select_pc),
    .select_ir2            (select_ir2),
    .select_pc2            (select_pc2),
    .select_pc3            (select_pc3),
    .select_ir3            (select_ir3),
    .select_ir4            (select_ir4),
    .select_x3             (select_x3),
    .select_y3             (select_y3),
    .select_md3            (select_md3),
    .select_operand1       (select_operand1),
    .select_operand2       (select_operand2),
    .select_md4            (select_md4),
    .select_datawrite      (select_datawrite),
    .select_z5             (select_z5),
    .reg_write_enable      (reg_write_enable),
    .data_write_signal     (data_write_signal)
  );

  logic [W-1:0] obs;
  assign obs = {select_pc, select_ir2, select_pc2, select_pc3, select_ir3,
                select_ir4, select_x3, select_y3, select_md3, select_operand1,
                select_operand2, select_md4, select_datawrite, select_z5,
                reg_write_enable, data_write_signal};

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1);
    return {12'h001, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
  endfunction
  function automatic logic [31:0] i_jal(input logic [4:0] rd);
    return {20'h00010, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] i_jalr(input logic [4:0] rd, rs1);
    return {12'h000, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  function automatic logic [31:0] i_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] i_auipc(input logic [4:0] rd);
    return {20'h00321, rd, 7'b0010111};
  endfunction

  // ---------------- expected-value shapes ----------------
  function automatic out_t safe_o();
    out_t e;
    e = '0;
    e.ir2 = 2'd1;
    e.ir3 = 2'd1;
    e.ir4 = 1'b1;
    return e;
  endfunction
  function automatic out_t stall_o();
    out_t e;
    e = '0;
    e.pc  = 2'd3;
    e.ir2 = 2'd2;
    e.pc2 = 1'b1;
    e.ir3 = 2'd1;
    e.pc3 = 1'b1;
    return e;
  endfunction
  function automatic out_t flush_o(input logic [1:0] pc);
    out_t e;
    e = '0;
    e.pc  = pc;
    e.ir2 = 2'd1;
    e.ir3 = 2'd1;
    e.ir4 = 1'b1;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           chk_cnt = 0;
  int           err_cnt = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: compare on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs, e);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input string tag, input logic [31:0] i2, i3, i4, i5,
                       input logic bc, input out_t e);
    @(posedge clk);
    #1;
    ir2_output = i2;
    ir3_output = i3;
    ir4_output = i4;
    ir5_output = i5;
    branch_control_output = bc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e;

    // Reset held for two edges; the second vector also covers the
    // released-but-not-yet-armed cycle.
    drive("reset_0", i_add(5'd3, 5'd1, 5'd2), '0, i_jal(5'd1), i_jal(5'd1), 1'b0, safe_o());
    drive("reset_1", i_add(5'd3, 5'd1, 5'd2), '0, '0, i_add(5'd1, 5'd2, 5'd3), 1'b0, safe_o());
    rst_ni = 1'b1;

    drive("idle_add", i_add(5'd3, 5'd1, 5'd2), '0, '0, '0, 1'b0, '0);

    // Execute forwarding
    e = '0; e.op1 = 2'd1;
    drive("fwd_op1_mem", '0, i_add(5'd4, 5'd2, 5'd3), i_add(5'd2, 5'd5, 5'd6), '0, 1'b0, e);
    e = '0; e.op1 = 2'd2; e.rwe = 1'b1;
    drive("fwd_op1_wb", '0, i_add(5'd4, 5'd2, 5'd3), '0, i_add(5'd2, 5'd5, 5'd6), 1'b0, e);
    e = '0; e.op1 = 2'd1; e.rwe = 1'b1;
    drive("fwd_op1_prio", '0, i_add(5'd4, 5'd2, 5'd3), i_add(5'd2, 5'd5, 5'd6),
          i_add(5'd2, 5'd7, 5'd8), 1'b0, e);
    e = '0; e.op2 = 2'd1;
    drive("fwd_op2_mem", '0, i_add(5'd4, 5'd2, 5'd3), i_addi(5'd3, 5'd7), '0, 1'b0, e);
    drive("no_fwd_load_mem", '0, i_add(5'd4, 5'd2, 5'd3), i_lw(5'd2, 5'd1, 12'd0), '0, 1'b0, '0);
    drive("no_fwd_x0", '0, i_add(5'd4, 5'd0, 5'd3), i_add(5'd0, 5'd1, 5'd1), '0, 1'b0, '0);
    e = '0; e.md4 = 2'd1;
    drive("fwd_md4_mem", '0, i_sw(5'd6, 5'd1, 12'd0), i_add(5'd6, 5'd7, 5'd8), '0, 1'b0, e);
    e = '0; e.md4 = 2'd2; e.rwe = 1'b1;
    drive("fwd_md4_wb", '0, i_sw(5'd6, 5'd1, 12'd0), '0, i_add(5'd6, 5'd7, 5'd8), 1'b0, e);

    // Load-use stall, then the store path that avoids it
    drive("load_use", i_add(5'd4, 5'd2, 5'd3), i_lw(5'd2, 5'd1, 12'd1), '0, '0, 1'b0, stall_o());
    e = '0; e.y3 = 2'd2;
    drive("store_no_stall", i_sw(5'd2, 5'd4, 12'd1), i_lw(5'd2, 5'd1, 12'd1), '0, '0, 1'b0, e);
    drive("store_advance", '0, i_sw(5'd2, 5'd4, 12'd1), i_lw(5'd2, 5'd1, 12'd1), '0, 1'b0, '0);
    e = '0; e.dwsel = 1'b1; e.dws = 1'b1; e.z5 = 2'd1; e.rwe = 1'b1;
    drive("datawrite_fwd", '0, '0, i_sw(5'd2, 5'd4, 12'd1), i_lw(5'd2, 5'd1, 12'd1), 1'b0, e);
    e = stall_o(); e.y3 = 2'd2;
    drive("store_rs1_stall", i_sw(5'd2, 5'd4, 12'd1), i_lw(5'd4, 5'd1, 12'd0), '0, '0, 1'b0, e);

    // Redirects
    drive("beq_taken", '0, '0, i_beq(5'd1, 5'd2), '0, 1'b1, flush_o(2'd1));
    drive("beq_not_taken", '0, '0, i_beq(5'd1, 5'd2), '0, 1'b0, '0);
    drive("jal_over_stall", i_add(5'd4, 5'd2, 5'd3), i_lw(5'd2, 5'd5, 12'd1), i_jal(5'd1), '0,
          1'b0, flush_o(2'd1));
    drive("jalr_redirect", '0, '0, i_jalr(5'd0, 5'd1), '0, 1'b0, flush_o(2'd2));

    // Writeback and memory
    e = '0; e.z5 = 2'd2; e.rwe = 1'b1;
    drive("wb_jal_link", '0, '0, '0, i_jal(5'd1), 1'b0, e);
    e = '0; e.z5 = 2'd2;
    drive("wb_jal_x0", '0, '0, '0, i_jal(5'd0), 1'b0, e);
    e = '0; e.dws = 1'b1;
    drive("mem_store", '0, '0, i_sw(5'd2, 5'd1, 12'd0), '0, 1'b0, e);
    e = '0; e.z5 = 2'd1; e.rwe = 1'b1;
    drive("wb_load", '0, '0, '0, i_lw(5'd5, 5'd1, 12'd0), 1'b0, e);

    // Decode operand selects
    e = '0; e.x3 = 2'd3; e.y3 = 2'd2;
    drive("dec_lui", i_lui(5'd5), '0, '0, '0, 1'b0, e);
    e = '0; e.x3 = 2'd2; e.y3 = 2'd2;
    drive("dec_auipc", i_auipc(5'd5), '0, '0, '0, 1'b0, e);
    e = '0; e.x3 = 2'd1; e.rwe = 1'b1;
    drive("dec_x3_wb", i_add(5'd4, 5'd2, 5'd3), '0, '0, i_add(5'd2, 5'd5, 5'd6), 1'b0, e);
    e = '0; e.y3 = 2'd1; e.md3 = 2'd1; e.rwe = 1'b1;
    drive("dec_y3_wb", i_add(5'd4, 5'd2, 5'd3), '0, '0, i_addi(5'd3, 5'd7), 1'b0, e);
    e = '0; e.y3 = 2'd2; e.md3 = 2'd1; e.rwe = 1'b1;
    drive("dec_md3_store", i_sw(5'd3, 5'd2, 12'd0), '0, '0, i_addi(5'd3, 5'd7), 1'b0, e);

    // Reset in mid-operation overrides a pending redirect
    rst_ni = 1'b0;
    drive("mid_reset", i_add(5'd3, 5'd1, 5'd2), '0, i_jal(5'd1), i_jal(5'd1), 1'b0, safe_o());
    rst_ni = 1'b1;
    e = '0; e.z5 = 2'd2; e.rwe = 1'b1;
    drive("after_reset", '0, '0, '0, i_jal(5'd1), 1'b0, e);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      err_cnt++;
      chk_cnt++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
